pc_ctrl: RTL and testbench

- Parametrised program-counter controller for the IF stage. It is the successor of the basic PC register.
- Adds a configurable reset vector and increment, prioritised jump/branch redirect, pipeline stall, debug single-step mode, and a post-halt drain counter.
- Sits between next-PC selection logic and instruction memory. o_pc addresses the fetch.

---
 rtl/pc_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pc_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
// Program-counter controller for the IF stage: reset vector, redirect priority, stall, single-step, post-halt drain.
// Latency: next PC registered, visible one cycle after the advance; o_pc_seq/o_valid are combinational.
// Backpressure: i_stall freezes the PC and drops any redirect/step offered that cycle; upstream must hold them.
// Optional: define PC_CTRL_FETCH_COUNTER_EN to add the saturating o_fetch_count output.

module pc_ctrl #(
  parameter int                  PC_SIZE      = 32,
  parameter int                  PC_STEP      = 4,
  parameter logic [PC_SIZE-1:0]  RESET_VECTOR = '0,
  parameter int                  DRAIN_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_step_mode,
  input  logic               i_step,
  input  logic               i_stall,
  input  logic               i_halt,
  input  logic               i_jump,
  input  logic [PC_SIZE-1:0] i_jump_addr,
  input  logic               i_branch,
  input  logic [PC_SIZE-1:0] i_branch_addr,
  output logic [PC_SIZE-1:0] o_pc,
  output logic [PC_SIZE-1:0] o_pc_seq,
  output logic               o_valid,
  output logic [2:0]         o_state,
  output logic               o_end
`ifdef PC_CTRL_FETCH_COUNTER_EN
  ,
  output logic [31:0]        o_fetch_count
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_END       = 3'd4
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t               state_q, state_d;
  logic [PC_SIZE-1:0]   pc_q, pc_d;
  logic [3:0]           drain_cnt_q, drain_cnt_d;
  logic [PC_SIZE-1:0]   next_pc;
  logic                 adv;
  logic                 valid;

  // Sequential successor and redirect priority: jump over branch over fall-through.
  always_comb begin
    o_pc_seq = pc_q + PC_SIZE'(PC_STEP);
    if (i_jump) begin
      next_pc = i_jump_addr;
    end else if (i_branch) begin
      next_pc = i_branch_addr;
    end else begin
      next_pc = o_pc_seq;
    end
  end

  // Next-state, PC and drain-counter logic; halt is evaluated before any advance.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drain_cnt_d = drain_cnt_q;
    valid       = 1'b0;
    adv         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pc_d        = RESET_VECTOR;
        drain_cnt_d = '0;
        if (i_start) begin
          state_d = i_step_mode ? ST_STEP_WAIT : ST_RUN;
        end
      end
      ST_RUN: begin
        valid = ~i_stall;
        if (i_halt) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end else begin
          adv = ~i_stall;
          if (i_step_mode) begin
            state_d = ST_STEP_WAIT;
          end
        end
      end
      ST_STEP_WAIT: begin
        valid = i_step & ~i_stall;
        if (i_halt) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end else begin
          // A step offered during a stall is simply lost.
          adv = i_step & ~i_stall;
          if (!i_step_mode) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = ST_END;
        end else begin
          drain_cnt_d = drain_cnt_q - 4'd1;
        end
      end
      ST_END: begin
        if (i_start && !i_halt) begin
          state_d = ST_IDLE;
          pc_d    = RESET_VECTOR;
        end
      end
      default: begin
        // Unreachable encodings recover to IDLE with a clean PC.
        state_d     = ST_IDLE;
        pc_d        = RESET_VECTOR;
        drain_cnt_d = '0;
      end
    endcase
    if (adv) begin
      pc_d = next_pc;
    end
  end

  // State, PC and drain-counter registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_VECTOR;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Output decode.
  always_comb begin
    o_pc    = pc_q;
    o_valid = valid;
    o_state = state_q;
    o_end   = (state_q == ST_END);
  end

`ifdef PC_CTRL_FETCH_COUNTER_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  // Saturating count of live fetches, cleared whenever IDLE is (re)entered.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (state_d == ST_IDLE) begin
      fetch_cnt_d = '0;
    end else if (valid && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  // Fetch-count register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fetch_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign o_fetch_count = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl with RESET_VECTOR=0x100, PC_STEP=4, DRAIN_CYCLES=4.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// Every comparison goes through check(); summary line at the end.

module tb_pc_ctrl;

  localparam int PW = 32;
  localparam logic [PW-1:0] RV = 32'h100;

  logic          clk = 1'b0;
  logic          reset, start, step_mode, step, stall, halt, jump, branch;
  logic [PW-1:0] jump_addr, branch_addr;
  logic [PW-1:0] pc, pc_seq;
  logic          valid, pend;
  logic [2:0]    state;
`ifdef PC_CTRL_FETCH_COUNTER_EN
  logic [31:0]   fetch_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_ctrl #(
    .PC_SIZE     (PW),
    .PC_STEP     (4),
    .RESET_VECTOR(RV),
    .DRAIN_CYCLES(4)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_step_mode  (step_mode),
    .i_step       (step),
    .i_stall      (stall),
    .i_halt       (halt),
    .i_jump       (jump),
    .i_jump_addr  (jump_addr),
    .i_branch     (branch),
    .i_branch_addr(branch_addr),
    .o_pc         (pc),
    .o_pc_seq     (pc_seq),
    .o_valid      (valid),
    .o_state      (state),
    .o_end        (pend)
`ifdef PC_CTRL_FETCH_COUNTER_EN
    ,
    .o_fetch_count(fetch_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0; stall = 1'b0;
    halt = 1'b0; jump = 1'b0; branch = 1'b0; jump_addr = '0; branch_addr = '0;
    tick(2);
    reset = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", pc, RV);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_end", 32'(pend), 32'd0);

    // Free run from the reset vector.
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("run_state", 32'(state), 32'd1);
    check("run_pc0", pc, 32'h100);
    check("run_valid", 32'(valid), 32'd1);
    check("run_seq", pc_seq, 32'h104);
    tick();
    check("run_pc1", pc, 32'h104);
    tick();
    check("run_pc2", pc, 32'h108);

    // Redirects: jump alone, jump+branch, branch alone.
    jump = 1'b1; jump_addr = 32'h10;
    tick();
    check("jmp_pc", pc, 32'h10);
    jump_addr = 32'h80; branch = 1'b1; branch_addr = 32'h40;
    tick();
    check("jmp_beats_br", pc, 32'h80);
    jump = 1'b0;
    tick();
    check("br_pc", pc, 32'h40);
    branch = 1'b0;

    // Wrap modulo 2^32.
    jump = 1'b1; jump_addr = 32'hFFFF_FFFC;
    tick();
    jump = 1'b0;
    #1;
    check("wrap_seq", pc_seq, 32'h0);
    tick();
    check("wrap_pc", pc, 32'h0);

    // Stall holds the PC for 3 cycles and discards a redirect offered meanwhile.
    jump = 1'b1; jump_addr = 32'h20;
    tick();
    check("stall_pre_pc", pc, 32'h20);
    stall = 1'b1; jump_addr = 32'h200;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_valid", 32'(valid), 32'd0);
      check("stall_pc", pc, 32'h20);
      tick();
    end
    stall = 1'b0; jump = 1'b0;
    #1;
    check("unstall_valid", 32'(valid), 32'd1);
    check("unstall_pc", pc, 32'h20);
    tick();
    check("post_stall_pc", pc, 32'h24);

    // Switching to step mode still advances on the transition cycle.
    step_mode = 1'b1;
    tick();
    check("sw_state", 32'(state), 32'd2);
    check("sw_pc", pc, 32'h28);
    for (int i = 0; i < 5; i++) begin
      check("sw_hold_pc", pc, 32'h28);
      check("sw_hold_valid", 32'(valid), 32'd0);
      tick();
    end
    step = 1'b1;
    #1;
    check("step_valid", 32'(valid), 32'd1);
    tick();
    step = 1'b0;
    #1;
    check("step_pc", pc, 32'h2C);
    step = 1'b1; stall = 1'b1;
    #1;
    check("step_stall_valid", 32'(valid), 32'd0);
    tick();
    step = 1'b0; stall = 1'b0;
    #1;
    check("step_stall_pc", pc, 32'h2C);
    tick();
    check("step_not_queued", pc, 32'h2C);
    step_mode = 1'b0;
    tick();
    check("back_run_state", 32'(state), 32'd1);
    check("back_run_pc", pc, 32'h2C);
    tick();
    check("back_run_pc1", pc, 32'h30);

    // Halt beats a simultaneous jump; 4 drain cycles then END.
    halt = 1'b1; jump = 1'b1; jump_addr = 32'h400;
    tick();
    halt = 1'b0; jump = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_state", 32'(state), 32'd3);
      check("drain_pc", pc, 32'h30);
      check("drain_valid", 32'(valid), 32'd0);
      tick();
    end
    check("end_state", 32'(state), 32'd4);
    check("end_flag", 32'(pend), 32'd1);
    check("end_pc", pc, 32'h30);
    start = 1'b1; halt = 1'b1;
    tick();
    check("end_start_halt", 32'(state), 32'd4);
    halt = 1'b0;
    tick();
    start = 1'b0;
    #1;
    check("restart_state", 32'(state), 32'd0);
    check("restart_pc", pc, RV);
    check("restart_end", 32'(pend), 32'd0);
`ifdef PC_CTRL_FETCH_COUNTER_EN
    check("fc_idle", fetch_count, 32'd0);
`endif

    // Ten live fetches, then reset mid-RUN.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(10);
    check("run10_pc", pc, 32'h128);
`ifdef PC_CTRL_FETCH_COUNTER_EN
    check("fc_ten", fetch_count, 32'd10);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_run_state", 32'(state), 32'd0);
    check("rst_run_pc", pc, RV);
    check("rst_run_end", 32'(pend), 32'd0);
`ifdef PC_CTRL_FETCH_COUNTER_EN
    check("fc_rst", fetch_count, 32'd0);
`endif

    // Reset mid-DRAIN.
    start = 1'b1;
    tick();
    start = 1'b0; halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
    check("pre_rst_drain", 32'(state), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_drain_state", 32'(state), 32'd0);
    check("rst_drain_pc", pc, RV);
    check("rst_drain_end", 32'(pend), 32'd0);

    // Step mode entered directly from IDLE.
    step_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("idle_to_step", 32'(state), 32'd2);
    check("idle_to_step_pc", pc, RV);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
